// File: rtl/oled_pkg.sv
// Shared constants, state encoding and the SSD1331 init command table for the
// OLED frame streamer.
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;

  typedef enum logic [1:0] {
    GAP   = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    INIT  = 2'd3
  } oled_state_e;

  typedef logic [15:0] rgb565_t;

  localparam int INIT_LEN   = 13;
  localparam int INIT_IDX_W = 4;

  // Display off, colour remap, start line, offset, normal mode, mux ratio,
  // master config, display on.
  function automatic logic [7:0] init_byte(input logic [INIT_IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'hAE;
      4'd1:    b = 8'hA0;
      4'd2:    b = 8'h72;
      4'd3:    b = 8'hA1;
      4'd4:    b = 8'h00;
      4'd5:    b = 8'hA2;
      4'd6:    b = 8'h00;
      4'd7:    b = 8'hA4;
      4'd8:    b = 8'hA8;
      4'd9:    b = 8'h3F;
      4'd10:   b = 8'hAD;
      4'd11:   b = 8'h8E;
      default: b = 8'hAF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/oled_spi_shifter.sv
// MSB-first SPI serialiser with an sclk divider; data is left-aligned in
// data_i and nbits_i selects how many bits are sent (8 or 16).
module oled_spi_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [15:0] data_i,
  input  logic [4:0]  nbits_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        done_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [15:0]   shreg_q, shreg_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          sclk_q, sclk_d;
  logic          active_q, active_d;
  logic          div_last;

  assign div_last = (div_cnt_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sclk_q    <= 1'b1;
      active_q  <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      active_q  <= active_d;
    end
  end

  // Each bit: CLK_DIV cycles with sclk low, then CLK_DIV with sclk high.
  // The next bit is shifted in on the same edge that drops sclk.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    active_d  = active_q;
    if (load_i) begin
      shreg_d   = data_i;
      bit_cnt_d = 4'(nbits_i - 5'd1);
      div_cnt_d = '0;
      sclk_d    = 1'b0;
      active_d  = 1'b1;
    end else if (active_q) begin
      if (!div_last) begin
        div_cnt_d = div_cnt_q + 1'b1;
      end else begin
        div_cnt_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else if (bit_cnt_q == 4'd0) begin
          active_d = 1'b0;
        end else begin
          shreg_d   = {shreg_q[14:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 4'd1;
          sclk_d    = 1'b0;
        end
      end
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = load_i ? data_i[15] : shreg_q[15];
  assign done_o = active_q & sclk_q & div_last & (bit_cnt_q == 4'd0);

endmodule

// File: rtl/oled_frame_streamer.sv
// Scans a WIDTH x HEIGHT frame, fetches RGB565 pixels and streams them to an
// SSD1331 over SPI. Define OLED_INIT_SEQ_EN to send the init table after reset.
module oled_frame_streamer
  import oled_pkg::*;
#(
  parameter int WIDTH     = OLED_WIDTH,
  parameter int HEIGHT    = OLED_HEIGHT,
  parameter int CLK_DIV   = 2,
  parameter int FRAME_GAP = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] oled_data,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic        frame_begin,
  output logic        busy,
  output logic        cs_n,
  output logic        dc,
  output logic        sclk,
  output logic        mosi
);

  localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_GAP - 1);
  localparam logic [6:0]    X_LAST   = 7'(WIDTH - 1);
  localparam logic [5:0]    Y_LAST   = 6'(HEIGHT - 1);

`ifdef OLED_INIT_SEQ_EN
  localparam oled_state_e RESET_STATE = INIT;
`else
  localparam oled_state_e RESET_STATE = GAP;
`endif

  oled_state_e   state_q, state_d;
  logic [6:0]    x_q, x_d;
  logic [5:0]    y_q, y_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  logic          gap_done, last_x, last_y;
  logic          sh_load, sh_done;
  rgb565_t       sh_data;
  logic [4:0]    sh_nbits;

`ifdef OLED_INIT_SEQ_EN
  logic [INIT_IDX_W-1:0] init_idx_q, init_idx_d;
  logic                  init_load_q, init_load_d;
  logic                  init_last;
  assign init_last = (init_idx_q == INIT_IDX_W'(INIT_LEN - 1));
`endif

  assign gap_done = (gap_cnt_q == GAP_LAST);
  assign last_x   = (x_q == X_LAST);
  assign last_y   = (y_q == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      x_q         <= '0;
      y_q         <= '0;
      gap_cnt_q   <= '0;
`ifdef OLED_INIT_SEQ_EN
      init_idx_q  <= '0;
      init_load_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      gap_cnt_q   <= gap_cnt_d;
`ifdef OLED_INIT_SEQ_EN
      init_idx_q  <= init_idx_d;
      init_load_q <= init_load_d;
`endif
    end
  end

  // en only matters once the gap has run out; a saturated gap starts at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GAP:     if (gap_done && en) state_d = FETCH;
      FETCH:   state_d = SHIFT;
      SHIFT:   if (sh_done) state_d = (last_x && last_y) ? GAP : FETCH;
`ifdef OLED_INIT_SEQ_EN
      INIT:    if (sh_done && init_last) state_d = GAP;
`endif
      default: state_d = GAP;
    endcase
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    gap_cnt_d = '0;
    if (state_q == GAP) begin
      gap_cnt_d = gap_done ? gap_cnt_q : gap_cnt_q + 1'b1;
    end
    if (state_q == SHIFT && sh_done) begin
      x_d = last_x ? 7'd0 : x_q + 7'd1;
      if (last_x) begin
        y_d = last_y ? 6'd0 : y_q + 6'd1;
      end
    end
  end

`ifdef OLED_INIT_SEQ_EN
  // A load cycle precedes every command byte, mirroring FETCH for pixels.
  always_comb begin
    init_idx_d  = init_idx_q;
    init_load_d = 1'b0;
    if (state_q == INIT && sh_done && !init_last) begin
      init_idx_d  = init_idx_q + 1'b1;
      init_load_d = 1'b1;
    end
  end
`endif

  always_comb begin
    cs_n        = (state_q == GAP);
    busy        = (state_q != GAP);
    frame_begin = (state_q == FETCH) && (x_q == 7'd0) && (y_q == 6'd0);
    sh_load     = (state_q == FETCH);
    sh_data     = oled_data;
    sh_nbits    = 5'd16;
`ifdef OLED_INIT_SEQ_EN
    dc          = (state_q != INIT);
    if (state_q == INIT) begin
      sh_load  = init_load_q;
      sh_data  = {init_byte(init_idx_q), 8'h00};
      sh_nbits = 5'd8;
    end
`else
    dc          = 1'b1;
`endif
  end

  oled_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load_i  (sh_load),
    .data_i  (sh_data),
    .nbits_i (sh_nbits),
    .sclk_o  (sclk),
    .mosi_o  (mosi),
    .done_o  (sh_done)
  );

  assign x = x_q;
  assign y = y_q;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Self-checking bench for oled_frame_streamer on a reduced 8x4 frame; decodes
// the SPI stream and compares words and timing against a raster-order model.
module tb_oled_frame_streamer;

  localparam int W         = 8;
  localparam int H         = 4;
  localparam int CDIV      = 2;
  localparam int GAPN      = 16;
  localparam int PIX       = 1 + 32 * CDIV;
  localparam int NPIX      = W * H;
  localparam int FRAME_PIX = NPIX * PIX;
`ifdef OLED_INIT_SEQ_EN
  localparam int INIT_N    = 13;
  localparam int INIT_CYC  = INIT_N * (1 + 16 * CDIV);
`else
  localparam int INIT_CYC  = 0;
`endif
  localparam int FB_OFF    = INIT_CYC + GAPN;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] oled_data;
  logic [6:0]  x;
  logic [5:0]  y;
  logic        frame_begin, busy, cs_n, dc, sclk, mosi;

  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          mode = 0;
  bit          noise_en = 1'b0;
  logic [15:0] noise = 16'h0;
  logic [15:0] pix_mem [NPIX];

  logic [15:0] words[$];
  logic [7:0]  init_bytes[$];
  int          fb_cyc[$];
  int          csr_cyc[$];
  int          rise_cnt = 0;
  int          dc_bad = 0;
  int          bitcnt = 0;
  logic [15:0] sh = 16'h0;
  logic        sclk_prev = 1'b1;
  logic        cs_prev = 1'b1;

  typedef struct {
    int          idx;
    logic [15:0] exp;
  } vec_t;
  vec_t vt [6];

  oled_frame_streamer #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .CLK_DIV   (CDIV),
    .FRAME_GAP (GAPN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .oled_data   (oled_data),
    .x           (x),
    .y           (y),
    .frame_begin (frame_begin),
    .busy        (busy),
    .cs_n        (cs_n),
    .dc          (dc),
    .sclk        (sclk),
    .mosi        (mosi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) noise <= 16'($urandom);

  // Pixel source; noise only while sclk is low, i.e. never during a fetch.
  always_comb begin
    case (mode)
      0:       oled_data = 16'hA5C3;
      1:       oled_data = {y, x, 3'b000};
      default: oled_data = pix_mem[(int'(y) * W + int'(x)) % NPIX];
    endcase
    if (noise_en && !sclk) oled_data = noise;
  end

  // SPI slave model: sample mosi on each rising sclk while selected.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      bitcnt = 0;
    end else begin
      if (!sclk_prev && sclk) begin
        rise_cnt = rise_cnt + 1;
        if (!cs_n) begin
          sh = {sh[14:0], mosi};
          bitcnt = bitcnt + 1;
          if (dc && bitcnt == 16) begin
            words.push_back(sh);
            bitcnt = 0;
          end else if (!dc && bitcnt == 8) begin
            init_bytes.push_back(sh[7:0]);
            bitcnt = 0;
          end
        end
      end
      if (cs_n) bitcnt = 0;
      if (frame_begin) fb_cyc.push_back(cyc);
      if (cs_n && !cs_prev) csr_cyc.push_back(cyc);
      if (!dc && fb_cyc.size() > 0) dc_bad = dc_bad + 1;
    end
    sclk_prev = sclk;
    cs_prev = cs_n;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int m, input int idx);
    int px = idx % W;
    int py = idx / W;
    case (m)
      0:       return 16'hA5C3;
      1:       return {6'(py), 7'(px), 3'b000};
      default: return pix_mem[idx];
    endcase
  endfunction

  function automatic logic [31:0] word_at(input int i);
    return (i < words.size()) ? {16'h0, words[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic int fb_at(input int i);
    return (i < fb_cyc.size()) ? fb_cyc[i] : -1;
  endfunction

  function automatic int csr_at(input int i);
    return (i < csr_cyc.size()) ? csr_cyc[i] : -1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic clear_log();
    words.delete();
    init_bytes.delete();
    fb_cyc.delete();
    csr_cyc.delete();
    rise_cnt = 0;
    dc_bad = 0;
  endtask

  // Three reset edges, check post-reset outputs, release; t0 = cycle 0.
  task automatic do_reset(input string tag, output int t0);
    reset = 1'b1;
    step(); step(); step();
    chk({tag, "_rst_x"}, 32'(x), 0);
    chk({tag, "_rst_y"}, 32'(y), 0);
    chk({tag, "_rst_sclk"}, 32'(sclk), 1);
    chk({tag, "_rst_fb"}, 32'(frame_begin), 0);
`ifndef OLED_INIT_SEQ_EN
    chk({tag, "_rst_mosi"}, 32'(mosi), 0);
    chk({tag, "_rst_csn"}, 32'(cs_n), 1);
    chk({tag, "_rst_dc"}, 32'(dc), 1);
    chk({tag, "_rst_busy"}, 32'(busy), 0);
`endif
    clear_log();
    reset = 1'b0;
    t0 = cyc;
  endtask

  initial begin
    int t0, fb0, c;
    logic [7:0] init_tab [13];

    vt[0] = '{0,  16'h0000};
    vt[1] = '{1,  16'h0008};
    vt[2] = '{7,  16'h0038};
    vt[3] = '{8,  16'h0400};
    vt[4] = '{9,  16'h0408};
    vt[5] = '{31, 16'h0C38};
    init_tab = '{8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00,
                 8'hA4, 8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hAF};
    for (int i = 0; i < NPIX; i++) pix_mem[i] = 16'($urandom);

    // Constant colour: first-frame latency, bit order, pixel period.
    mode = 0;
    en = 1'b1;
    do_reset("t1", t0);
    fb0 = t0 + FB_OFF;
    goto(fb0 - 1);
    chk("t1_fb_early", 32'(frame_begin), 0);
    goto(fb0);
    chk("t1_fb", 32'(frame_begin), 1);
    chk("t1_fb_x", 32'(x), 0);
    chk("t1_fb_y", 32'(y), 0);
    chk("t1_fb_csn", 32'(cs_n), 0);
    chk("t1_fb_busy", 32'(busy), 1);
    goto(fb0 + PIX - 1);
    chk("t1_x_hold", 32'(x), 0);
    goto(fb0 + PIX);
    chk("t1_x_step", 32'(x), 1);
    goto(fb0 + PIX + 5);
    chk("t1_word0", word_at(0), 32'(exp_word(0, 0)));
    chk("t1_fb_cyc", fb_at(0), fb0);
    chk("t1_dc", dc_bad, 0);
`ifdef OLED_INIT_SEQ_EN
    chk("t1_init_n", init_bytes.size(), 13);
    for (int i = 0; i < 13; i++)
      chk($sformatf("t1_init_%0d", i),
          (i < init_bytes.size()) ? 32'(init_bytes[i]) : 32'hFFFF_FFFF, 32'(init_tab[i]));
`endif
    $display("phase 1 done: %0d words", words.size());

    // Coordinate-coded pixels over a full frame: raster order and gap timing.
    mode = 1;
    do_reset("t2", t0);
    fb0 = t0 + FB_OFF;
    goto(fb0 + FRAME_PIX + GAPN + 2);
    chk("t2_nwords", words.size(), NPIX);
    for (int i = 0; i < NPIX; i++)
      chk($sformatf("t2_word%0d", i), word_at(i), 32'(exp_word(1, i)));
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_vec%0d", vt[i].idx), word_at(vt[i].idx), 32'(vt[i].exp));
    chk("t2_csn_rise", csr_at(0), fb0 + FRAME_PIX);
    chk("t2_gap_len", fb_at(1) - csr_at(0), GAPN);
    chk("t2_dc", dc_bad, 0);
    $display("phase 2 done: %0d words", words.size());

    // Random pixels with noise outside fetch; en drops mid-frame.
    mode = 2;
    noise_en = 1'b1;
    do_reset("t3", t0);
    fb0 = t0 + FB_OFF;
    goto(fb0 + 10 * PIX + 30);
    en = 1'b0;
    goto(fb0 + FRAME_PIX + 400);
    chk("t3_nwords", words.size(), NPIX);
    for (int i = 0; i < NPIX; i++)
      chk($sformatf("t3_word%0d", i), word_at(i), 32'(exp_word(2, i)));
    chk("t3_nfb", fb_cyc.size(), 1);
    chk("t3_csn_idle", 32'(cs_n), 1);
    chk("t3_busy_idle", 32'(busy), 0);
    chk("t3_csn_rise", csr_at(0), fb0 + FRAME_PIX);
    c = cyc;
    en = 1'b1;
    goto(c + 3);
    chk("t3_restart_fb", fb_at(1), c + 1);
    noise_en = 1'b0;
    $display("phase 3 done: %0d words", words.size());

    // Reset in the middle of a pixel shift.
    mode = 1;
    do_reset("t4", t0);
    fb0 = t0 + FB_OFF;
    goto(fb0 + 3 * PIX + 20);
    reset = 1'b1;
    step();
    chk("t4_abort_sclk", 32'(sclk), 1);
    chk("t4_abort_x", 32'(x), 0);
    chk("t4_abort_y", 32'(y), 0);
`ifndef OLED_INIT_SEQ_EN
    chk("t4_abort_csn", 32'(cs_n), 1);
`endif
    clear_log();
    reset = 1'b0;
    t0 = cyc;
    goto(t0 + FB_OFF);
    chk("t4_fb", 32'(frame_begin), 1);
`ifndef OLED_INIT_SEQ_EN
    chk("t4_no_sclk", rise_cnt, 0);
`endif
    goto(t0 + FB_OFF + PIX + 2);
    chk("t4_nwords", words.size(), 1);
    chk("t4_word0", word_at(0), 32'(exp_word(1, 0)));
    $display("phase 4 done: %0d words", words.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
